// File: rtl/bus_pkg.sv
// Shared types and constants for the output-bus selector family.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   idx_w(n)     - index width for an n-way one-hot select, never below 1
//   sel_class_t  - classification of a one-hot select vector
//   BUS_WIDTH    - default bus word width
//   BUS_N_SRC    - default number of bus sources
package bus_pkg;

  localparam int BUS_WIDTH = 8;
  localparam int BUS_N_SRC = 6;

  typedef enum logic [1:0] {
    SEL_ZERO  = 2'd0,
    SEL_ONE   = 2'd1,
    SEL_MULTI = 2'd2
  } sel_class_t;

  // A 1-bit index is still needed for n <= 2, where clog2 would give 0 or 1.
  function automatic int idx_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/onehot_classify.sv
// Classifies a select vector as zero / one-hot / multi-hot and encodes its index.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports:
//   sel       in  N_SRC  select vector, bit i selects source i
//   sel_class out        SEL_ZERO, SEL_ONE or SEL_MULTI
//   sel_idx   out IDX_W  encoded index; meaningful only when sel_class is SEL_ONE
module onehot_classify
  import bus_pkg::*;
#(
  parameter  int N_SRC = BUS_N_SRC,
  localparam int IDX_W = idx_w(N_SRC)
) (
  input  logic [N_SRC-1:0] sel,
  output sel_class_t       sel_class,
  output logic [IDX_W-1:0] sel_idx
);

  logic any_set;
  logic multi_set;

  // Two running flags are enough: 'multi' trips as soon as a set bit is
  // seen after another one, so no full popcount is needed.
  always_comb begin
    any_set   = 1'b0;
    multi_set = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      multi_set = multi_set | (any_set & sel[i]);
      any_set   = any_set | sel[i];
    end
  end

  // OR of the indices of all set bits. Exact for a one-hot input; garbage
  // otherwise, which callers must ignore outside SEL_ONE.
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (sel[i]) begin
        sel_idx = sel_idx | IDX_W'(i);
      end
    end
  end

  always_comb begin
    sel_class = SEL_ZERO;
    if (multi_set) begin
      sel_class = SEL_MULTI;
    end else if (any_set) begin
      sel_class = SEL_ONE;
    end
  end

endmodule

// File: rtl/bus_sel_reg.sv
// Registered one-hot bus selector with multi-hot conflict detection.
// Latency: 1 cycle from select/data to bus_out and status outputs.
// Backpressure: none; accepts a new select every cycle.
//
// Ports:
//   clk, rst_n       clock and asynchronous active-low reset
//   src_sel          one-hot source select (N_SRC bits)
//   src_data         flattened source words, source i at [i*WIDTH +: WIDTH]
//   err_clear        synchronous clear of conflict_sticky / conflict_cnt
//   bus_out          registered bus word
//   bus_valid        bus_out came from exactly one source last cycle
//   bus_src          index of the last legal driver
//   conflict         pulse: last cycle's select was multi-hot
//   conflict_sticky  a conflict has occurred since reset / last clear
//   conflict_cnt     saturating conflict count
module bus_sel_reg
  import bus_pkg::*;
#(
  parameter  int WIDTH     = BUS_WIDTH,
  parameter  int N_SRC     = BUS_N_SRC,
  parameter  bit HOLD_IDLE = 1'b0,
  parameter  int CNT_W     = 4,
  localparam int IDX_W     = idx_w(N_SRC)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_SRC-1:0]       src_sel,
  input  logic [N_SRC*WIDTH-1:0] src_data,
  input  logic                   err_clear,
  output logic [WIDTH-1:0]       bus_out,
  output logic                   bus_valid,
  output logic [IDX_W-1:0]       bus_src,
  output logic                   conflict,
  output logic                   conflict_sticky,
  output logic [CNT_W-1:0]       conflict_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  sel_class_t       sel_class;
  logic [IDX_W-1:0] sel_idx;
  logic [WIDTH-1:0] sel_word;
  logic [CNT_W-1:0] cnt_nxt;
  logic             sticky_nxt;

  onehot_classify #(
    .N_SRC(N_SRC)
  ) u_classify (
    .sel      (src_sel),
    .sel_class(sel_class),
    .sel_idx  (sel_idx)
  );

  // AND-OR slice mux driven straight from the select bits. Only used for
  // SEL_ONE, so the multi-hot OR of several words never reaches the bus.
  always_comb begin
    sel_word = '0;
    for (int i = 0; i < N_SRC; i++) begin
      sel_word = sel_word | (src_data[i*WIDTH +: WIDTH] & {WIDTH{src_sel[i]}});
    end
  end

  // Conflict status: a new conflict in the same cycle as err_clear wins and
  // restarts the count at one rather than being lost.
  always_comb begin
    cnt_nxt    = conflict_cnt;
    sticky_nxt = conflict_sticky;
    if (sel_class == SEL_MULTI) begin
      sticky_nxt = 1'b1;
      if (err_clear) begin
        cnt_nxt = CNT_W'(1);
      end else if (conflict_cnt != CNT_MAX) begin
        cnt_nxt = conflict_cnt + CNT_W'(1);
      end
    end else if (err_clear) begin
      sticky_nxt = 1'b0;
      cnt_nxt    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_out   <= '0;
      bus_valid <= 1'b0;
      bus_src   <= '0;
      conflict  <= 1'b0;
    end else begin
      unique case (sel_class)
        SEL_ONE: begin
          bus_out   <= sel_word;
          bus_valid <= 1'b1;
          bus_src   <= sel_idx;
          conflict  <= 1'b0;
        end
        SEL_MULTI: begin
          // Multi-hot always blanks the bus, even in hold mode.
          bus_out   <= '0;
          bus_valid <= 1'b0;
          conflict  <= 1'b1;
        end
        default: begin
          if (!HOLD_IDLE) begin
            bus_out <= '0;
          end
          bus_valid <= 1'b0;
          conflict  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_sticky <= 1'b0;
      conflict_cnt    <= '0;
    end else begin
      conflict_sticky <= sticky_nxt;
      conflict_cnt    <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_bus_sel_reg.sv
// Directed bench for bus_sel_reg: one instance per HOLD_IDLE setting on shared inputs.
// Latency: expects outputs one clock after inputs are sampled.
// Backpressure: n/a.
module tb_bus_sel_reg;

  localparam int WIDTH = 8;
  localparam int N_SRC = 6;
  localparam int CNT_W = 4;
  localparam int IDX_W = 3;

  logic                   clk;
  logic                   rst_n;
  logic [N_SRC-1:0]       src_sel;
  logic [N_SRC*WIDTH-1:0] src_data;
  logic                   err_clear;

  logic [WIDTH-1:0] bus_out0, bus_out1;
  logic             bus_valid0, bus_valid1;
  logic [IDX_W-1:0] bus_src0, bus_src1;
  logic             conflict0, conflict1;
  logic             sticky0, sticky1;
  logic [CNT_W-1:0] cnt0, cnt1;

  int n_chk  = 0;
  int n_pass = 0;

  bus_sel_reg #(.WIDTH(WIDTH), .N_SRC(N_SRC), .HOLD_IDLE(1'b0), .CNT_W(CNT_W)) dut0 (
    .clk(clk), .rst_n(rst_n), .src_sel(src_sel), .src_data(src_data),
    .err_clear(err_clear), .bus_out(bus_out0), .bus_valid(bus_valid0),
    .bus_src(bus_src0), .conflict(conflict0), .conflict_sticky(sticky0),
    .conflict_cnt(cnt0)
  );

  bus_sel_reg #(.WIDTH(WIDTH), .N_SRC(N_SRC), .HOLD_IDLE(1'b1), .CNT_W(CNT_W)) dut1 (
    .clk(clk), .rst_n(rst_n), .src_sel(src_sel), .src_data(src_data),
    .err_clear(err_clear), .bus_out(bus_out1), .bus_valid(bus_valid1),
    .bus_src(bus_src1), .conflict(conflict1), .conflict_sticky(sticky1),
    .conflict_cnt(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [WIDTH-1:0] v);
    src_data[i*WIDTH +: WIDTH] = v;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " out0"},    32'(bus_out0),   32'h0);
    check({tag, " out1"},    32'(bus_out1),   32'h0);
    check({tag, " valid"},   32'(bus_valid0 | bus_valid1), 32'h0);
    check({tag, " src"},     32'(bus_src0 | bus_src1),     32'h0);
    check({tag, " confl"},   32'(conflict0 | conflict1),   32'h0);
    check({tag, " sticky"},  32'(sticky0 | sticky1),       32'h0);
    check({tag, " cnt"},     32'(cnt0 | cnt1),             32'h0);
  endtask

  initial begin
    rst_n     = 1'b0;
    err_clear = 1'b0;
    src_sel   = 6'b101101;
    src_data  = 48'h0123_4567_89AB;
    step();
    step();
    check_all_zero("reset");

    // Release with source 2 selected.
    src_sel = 6'b000100;
    set_src(2, 8'hA5);
    rst_n = 1'b1;
    step();
    check("rel out",   32'(bus_out0),   32'hA5);
    check("rel valid", 32'(bus_valid0), 32'h1);
    check("rel src",   32'(bus_src0),   32'h2);

    // Walking one, back to back.
    for (int i = 0; i < N_SRC; i++) set_src(i, 8'h10 + 8'(i));
    for (int i = 0; i < N_SRC; i++) begin
      src_sel = 6'(1 << i);
      step();
      check($sformatf("sweep out%0d", i),   32'(bus_out0),  32'h10 + i);
      check($sformatf("sweep src%0d", i),   32'(bus_src0),  i);
      check($sformatf("sweep confl%0d", i), 32'(conflict0), 32'h0);
    end

    // Idle after source 3.
    set_src(3, 8'h3C);
    src_sel = 6'b001000;
    step();
    src_sel = 6'b000000;
    step();
    check("idle out0",   32'(bus_out0),   32'h00);
    check("idle valid0", 32'(bus_valid0), 32'h0);
    check("idle out1",   32'(bus_out1),   32'h3C);
    check("idle valid1", 32'(bus_valid1), 32'h0);
    check("idle src1",   32'(bus_src1),   32'h3);

    // Single conflict; hold instance must also blank.
    src_sel = 6'b000011;
    step();
    check("conf out0",  32'(bus_out0),  32'h0);
    check("conf out1",  32'(bus_out1),  32'h0);
    check("conf pulse", 32'(conflict0), 32'h1);
    check("conf stk",   32'(sticky0),   32'h1);
    check("conf cnt",   32'(cnt0),      32'h1);
    check("conf src",   32'(bus_src1),  32'h3);
    src_sel = 6'b000000;
    step();
    check("conf2 pulse", 32'(conflict0), 32'h0);
    check("conf2 stk",   32'(sticky0),   32'h1);
    check("conf2 cnt",   32'(cnt0),      32'h1);

    // 20 more conflicts: count goes 2..15 and then saturates.
    src_sel = 6'b100100;
    for (int k = 0; k < 20; k++) begin
      step();
      if (k == 12) check("sat pre cnt", 32'(cnt0), 32'd14);
    end
    check("sat cnt",  32'(cnt1),    32'd15);
    check("sat stk",  32'(sticky1), 32'h1);

    // Clear with a coincident conflict, then clear alone.
    err_clear = 1'b1;
    src_sel   = 6'b110000;
    step();
    check("clr+m cnt",   32'(cnt0),      32'h1);
    check("clr+m stk",   32'(sticky0),   32'h1);
    check("clr+m pulse", 32'(conflict0), 32'h1);
    set_src(0, 8'h5A);
    src_sel = 6'b000001;
    step();
    check("clr cnt",   32'(cnt0),      32'h0);
    check("clr stk",   32'(sticky0),   32'h0);
    check("clr out",   32'(bus_out0),  32'h5A);
    check("clr valid", 32'(bus_valid0), 32'h1);
    err_clear = 1'b0;

    // Async reset between edges during traffic, with sticky set beforehand.
    src_sel = 6'b000011;
    step();
    set_src(4, 8'h44);
    src_sel = 6'b010000;
    step();
    check("pre-rst out1", 32'(bus_out1), 32'h44);
    check("pre-rst stk",  32'(sticky1),  32'h1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async rst");
    #1 rst_n = 1'b1;
    step();
    check("resume out",   32'(bus_out0),   32'h44);
    check("resume valid", 32'(bus_valid0), 32'h1);
    check("resume src",   32'(bus_src0),   32'h4);
    src_sel = 6'b000000;
    step();
    check("resume hold",  32'(bus_out1),   32'h44);
    check("resume out0",  32'(bus_out0),   32'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bus_sel_reg.md
# bus_sel_reg

Registered, parametrised successor to the computer's one-hot output-bus selector. It picks one of `N_SRC` source words, each `WIDTH` bits wide, onto the shared data bus using a one-hot select from the control unit. It registers the result and reports which source drove the bus. It also detects illegal multi-hot selects and records them with a sticky flag and a saturating counter. It sits between the register file, ALU, memory, PC and instruction register and the bus consumers, one pipeline stage after control decode.

## Interface
Parameters:
- `WIDTH`, 8, bus word width in bits.
- `N_SRC`, 6, number of bus sources (≥2).
- `HOLD_IDLE`, 0, 0 = bus reads zero when no source is selected; 1 = bus holds its last driven value.
- `CNT_W`, 4, width of the conflict counter.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `src_sel` in `N_SRC`: one-hot source select; bit i selects source i.
- `src_data` in `N_SRC*WIDTH`: flattened source words; source i occupies bits `[i*WIDTH +: WIDTH]`.
- `err_clear` in 1: synchronous clear of the conflict status.
- `bus_out` out `WIDTH`: registered bus value.
- `bus_valid` out 1: `bus_out` was driven by exactly one source in the previous cycle.
- `bus_src` out `IDX_W`: index of the last legal driver, where `IDX_W = max(1, clog2(N_SRC))`.
- `conflict` out 1: one-cycle pulse, previous cycle's select was multi-hot.
- `conflict_sticky` out 1: at least one conflict has occurred since reset or the last clear.
- `conflict_cnt` out `CNT_W`: number of conflicts, saturating at all-ones.

## Operation
The select is classified every cycle as ZERO (no bits set), ONE (exactly one bit set) or MULTI (two or more bits set).

- **ONE**
  - `bus_out` ← selected word.
  - `bus_valid` ← 1.
  - `bus_src` ← encoded index.
  - `conflict` ← 0.
- **ZERO**
  - `bus_valid` ← 0.
  - `bus_out` ← 0 when `HOLD_IDLE=0`; unchanged when `HOLD_IDLE=1`.
  - `bus_src` unchanged.
  - `conflict` ← 0.
- **MULTI**
  - `bus_out` ← 0, regardless of `HOLD_IDLE`.
  - `bus_valid` ← 0.
  - `bus_src` unchanged.
  - `conflict` ← 1.
  - `conflict_sticky` ← 1.
  - `conflict_cnt` ← `conflict_cnt + 1`; it stays at `2^CNT_W − 1` once reached.
- **`err_clear`**
  - Sets `conflict_sticky` and `conflict_cnt` to 0 on the next edge.
  - If a MULTI select occurs in the same cycle, the new event wins: sticky = 1, count = 1.
  - `err_clear` has no effect on `bus_out`, `bus_valid`, `bus_src` or `conflict`.
- **Multi-bit `src_data`** has no meaning outside the selected slice; unselected words are don't-care.

## Timing
- **Latency:** fixed at 1 cycle, select and data at edge k → outputs after edge k+1. No back-pressure, one new word every cycle.
- **Reset values:** all outputs go to 0 immediately on `rst_n` low, independent of `clk`: `bus_out`, `bus_valid`, `bus_src`, `conflict`, `conflict_sticky`, `conflict_cnt`.
- **Reset release:** the first edge with `rst_n` high samples normally.
- **Reset mid-run:** reset asserted mid-stream discards the in-flight word. A held value (`HOLD_IDLE=1`) is lost and reads 0 after reset.
- **Saturation:** the counter does not wrap. At `CNT_W=4`, the 16th and later conflicts leave it at 15.
- **Back-to-back changes:** consecutive ONE selects on different sources change `bus_out` every cycle with no bubble.

## Structure
- **Shared package `bus_pkg`:**
  - `function idx_w(n)` returning `max(1, clog2(n))`.
  - Enum `sel_class_t {SEL_ZERO, SEL_ONE, SEL_MULTI}`.
  - Default constants `BUS_WIDTH=8`, `BUS_N_SRC=6`.
- **Sub-module `onehot_classify`:** purely combinational. It takes the `N_SRC` select vector and outputs `sel_class_t` plus the encoded index.
  - The index is valid only for ONE.
  - It is reused by the future register-file write-enable checker.
- **`bus_sel_reg` top:** contains the slice mux, output registers, sticky flag and saturating counter.

## Test plan
- **Reset:** with `rst_n` low and a random select, all outputs are 0. On release with `src_sel=6'b000100` and source 2 = `8'hA5`, the outputs one cycle later are `bus_out=8'hA5`, `bus_valid=1`, `bus_src=2`.
- **Sweep:** walk a one through all 6 select bits with source i data = `8'h10+i`. `bus_out` follows `8'h10..8'h15` one cycle behind, `bus_src` = 0..5, and `conflict` never asserts.
- **Idle:** drive source 3 = `8'h3C`, then `src_sel=0`.
  - With `HOLD_IDLE=0`: `bus_out=0`, `bus_valid=0`.
  - With `HOLD_IDLE=1`: `bus_out` stays `8'h3C`, `bus_valid=0`, `bus_src=3`.
- **Conflict:** apply `src_sel=6'b000011` for one cycle. The next cycle shows `bus_out=0`, `conflict=1`, sticky=1, `conflict_cnt=1`. The cycle after that shows `conflict=0` and sticky=1.
- **Saturation and clear:** 20 consecutive MULTI cycles leave `conflict_cnt=15`. Then `err_clear` together with a MULTI select gives `conflict_cnt=1`, sticky=1. `err_clear` alone gives count 0, sticky 0.
- **Async reset mid-stream:** pulse `rst_n` low between clock edges during valid traffic. Outputs go to 0 before the next edge, and traffic resumes with 1-cycle latency.
